// File: rtl/xadc_drp_sampler.sv
// xadc_drp_sampler: reads each XADC conversion result over DRP after its
// end-of-conversion pulse and presents it to the analog monitors through a
// one-entry valid/ready output register. It flags dropped samples and DRP
// reads whose DRDY never arrives.
module xadc_drp_sampler #(
   parameter logic [31:0] CHAN_MASK   = 32'hFFFF_FFFF,
   parameter int          TIMEOUT_CYC = 64
) (
   input  logic        CLK,
   input  logic        RESETN,
   input  logic        EOC_IN,
   input  logic [4:0]  CHANNEL_IN,
   output logic        DEN,
   output logic        DWE,
   output logic [6:0]  DADDR,
   input  logic        DRDY,
   input  logic [15:0] DO_IN,
   output logic [11:0] SAMPLE,
   output logic [4:0]  SAMPLE_CH,
   output logic        SAMPLE_VALID,
   input  logic        SAMPLE_READY,
   output logic        BUSY,
   output logic        OVERFLOW,
   output logic        TIMEOUT_ERR,
   input  logic        CLR_FLAGS
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;

   logic eoc_accept;
   logic drdy_hit;
   logic can_load;
   logic overflow_set;
   logic timeout_set;
   logic unused_do_bits;

   // The low four DO bits carry no result information.
   assign unused_do_bits = ^DO_IN[3:0];

   // This block is the only DRP master and never writes.
   assign DWE = 1'b0;

   assign eoc_accept   = EOC_IN & CHAN_MASK[CHANNEL_IN];
   assign drdy_hit     = (state == S_WAIT) & DRDY;
   assign can_load     = ~SAMPLE_VALID | SAMPLE_READY;
   assign overflow_set = (eoc_accept & (state != S_IDLE)) | (drdy_hit & ~can_load);
   assign timeout_set  = (state == S_WAIT) & ~DRDY & (wait_cnt == CNT_LAST);

   // DRP sequencer with registered outputs: output register and sticky flags
   // live here too so that every output changes on the same edge as the state.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state        <= S_IDLE;
         wait_cnt     <= '0;
         DEN          <= 1'b0;
         DADDR        <= '0;
         BUSY         <= 1'b0;
         SAMPLE       <= '0;
         SAMPLE_CH    <= '0;
         SAMPLE_VALID <= 1'b0;
         OVERFLOW     <= 1'b0;
         TIMEOUT_ERR  <= 1'b0;
      end else begin
         OVERFLOW    <= overflow_set | (OVERFLOW & ~CLR_FLAGS);
         TIMEOUT_ERR <= timeout_set | (TIMEOUT_ERR & ~CLR_FLAGS);

         if (drdy_hit && can_load) begin
            SAMPLE       <= DO_IN[15:4];
            SAMPLE_CH    <= DADDR[4:0];
            SAMPLE_VALID <= 1'b1;
         end else if (SAMPLE_VALID && SAMPLE_READY) begin
            SAMPLE_VALID <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (eoc_accept) begin
                  state <= S_REQ;
                  DEN   <= 1'b1;
                  DADDR <= {2'b00, CHANNEL_IN};
                  BUSY  <= 1'b1;
               end
            end
            S_REQ: begin
               state    <= S_WAIT;
               DEN      <= 1'b0;
               wait_cnt <= '0;
            end
            S_WAIT: begin
               if (DRDY || timeout_set) begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               DEN   <= 1'b0;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// tb_xadc_drp_sampler: directed bench for xadc_drp_sampler. A second instance
// with only channel 0 enabled shares the inputs to exercise channel masking.
module tb_xadc_drp_sampler;

   logic        CLK = 1'b0;
   logic        RESETN;
   logic        EOC_IN;
   logic [4:0]  CHANNEL_IN;
   logic        DRDY;
   logic [15:0] DO_IN;
   logic        SAMPLE_READY;
   logic        CLR_FLAGS;

   logic        den, dwe, sample_valid, busy, overflow, timeout_err;
   logic [6:0]  daddr;
   logic [11:0] sample;
   logic [4:0]  sample_ch;

   logic        den_m, dwe_m, sample_valid_m, busy_m, overflow_m, timeout_err_m;
   logic [6:0]  daddr_m;
   logic [11:0] sample_m;
   logic [4:0]  sample_ch_m;

   int checks = 0;
   int errors = 0;
   int den_cnt = 0;
   int den_m_cnt = 0;
   int den_snap;

   xadc_drp_sampler dut (
      .CLK(CLK), .RESETN(RESETN), .EOC_IN(EOC_IN), .CHANNEL_IN(CHANNEL_IN),
      .DEN(den), .DWE(dwe), .DADDR(daddr), .DRDY(DRDY), .DO_IN(DO_IN),
      .SAMPLE(sample), .SAMPLE_CH(sample_ch), .SAMPLE_VALID(sample_valid),
      .SAMPLE_READY(SAMPLE_READY), .BUSY(busy), .OVERFLOW(overflow),
      .TIMEOUT_ERR(timeout_err), .CLR_FLAGS(CLR_FLAGS)
   );

   xadc_drp_sampler #(.CHAN_MASK(32'h0000_0001), .TIMEOUT_CYC(64)) dut_m (
      .CLK(CLK), .RESETN(RESETN), .EOC_IN(EOC_IN), .CHANNEL_IN(CHANNEL_IN),
      .DEN(den_m), .DWE(dwe_m), .DADDR(daddr_m), .DRDY(DRDY), .DO_IN(DO_IN),
      .SAMPLE(sample_m), .SAMPLE_CH(sample_ch_m), .SAMPLE_VALID(sample_valid_m),
      .SAMPLE_READY(SAMPLE_READY), .BUSY(busy_m), .OVERFLOW(overflow_m),
      .TIMEOUT_ERR(timeout_err_m), .CLR_FLAGS(CLR_FLAGS)
   );

   // 100 MHz clock
   always #5 CLK = ~CLK;

   // Count DRP enable pulses of both instances
   always @(posedge CLK) begin
      if (den === 1'b1) den_cnt++;
      if (den_m === 1'b1) den_m_cnt++;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete read: EOC, REQ cycle, gap WAIT cycles, then DRDY with data
   task automatic applyStimulus(input logic [4:0] ch, input logic [15:0] data, input int gap);
      EOC_IN = 1'b1;
      CHANNEL_IN = ch;
      tick();
      EOC_IN = 1'b0;
      tick();
      repeat (gap) tick();
      DRDY = 1'b1;
      DO_IN = data;
      tick();
      DRDY = 1'b0;
   endtask

   initial begin
      RESETN = 1'b0;
      EOC_IN = 1'b0;
      CHANNEL_IN = '0;
      DRDY = 1'b0;
      DO_IN = '0;
      SAMPLE_READY = 1'b0;
      CLR_FLAGS = 1'b0;
      repeat (3) tick();

      // Reset state
      checkOutput("rst_den", den, 0);
      checkOutput("rst_dwe", dwe, 0);
      checkOutput("rst_daddr", daddr, 0);
      checkOutput("rst_valid", sample_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_flags", {overflow, timeout_err}, 0);
      RESETN = 1'b1;
      tick();

      // 1: basic read, ch 3, DRDY 4 cycles after DEN
      EOC_IN = 1'b1;
      CHANNEL_IN = 5'h03;
      tick();
      EOC_IN = 1'b0;
      checkOutput("t1_den", den, 1);
      checkOutput("t1_daddr", daddr, 7'h03);
      checkOutput("t1_busy", busy, 1);
      tick();
      checkOutput("t1_den_low", den, 0);
      checkOutput("t1_daddr_hold", daddr, 7'h03);
      repeat (2) tick();
      DRDY = 1'b1;
      DO_IN = 16'hABCD;
      tick();
      DRDY = 1'b0;
      checkOutput("t1_sample", sample, 12'hABC);
      checkOutput("t1_ch", sample_ch, 5'd3);
      checkOutput("t1_valid", sample_valid, 1);
      checkOutput("t1_busy_end", busy, 0);
      repeat (2) tick();
      checkOutput("t1_valid_hold", sample_valid, 1);
      SAMPLE_READY = 1'b1;
      tick();
      SAMPLE_READY = 1'b0;
      checkOutput("t1_valid_clr", sample_valid, 0);
      checkOutput("t1_sample_keep", sample, 12'hABC);
      checkOutput("t1_dwe", dwe, 0);

      // 2: consumer stalled, second result dropped
      applyStimulus(5'd1, 16'h1230, 2);
      checkOutput("t2_first", sample, 12'h123);
      checkOutput("t2_ovf0", overflow, 0);
      applyStimulus(5'd2, 16'h4560, 2);
      checkOutput("t2_keep", sample, 12'h123);
      checkOutput("t2_keep_ch", sample_ch, 5'd1);
      checkOutput("t2_valid", sample_valid, 1);
      checkOutput("t2_ovf1", overflow, 1);
      CLR_FLAGS = 1'b1;
      tick();
      CLR_FLAGS = 1'b0;
      checkOutput("t2_ovf_clr", overflow, 0);
      SAMPLE_READY = 1'b1;
      tick();
      SAMPLE_READY = 1'b0;
      checkOutput("t2_drain", sample_valid, 0);

      // 3: DRDY never arrives
      EOC_IN = 1'b1;
      CHANNEL_IN = 5'd4;
      tick();
      EOC_IN = 1'b0;
      checkOutput("t3_den", den, 1);
      repeat (64) tick();
      checkOutput("t3_not_yet", timeout_err, 0);
      checkOutput("t3_busy_wait", busy, 1);
      tick();
      checkOutput("t3_timeout", timeout_err, 1);
      checkOutput("t3_busy_end", busy, 0);
      DRDY = 1'b1;
      DO_IN = 16'hFFFF;
      tick();
      DRDY = 1'b0;
      tick();
      checkOutput("t3_late_valid", sample_valid, 0);
      checkOutput("t3_late_sample", sample, 12'h123);
      CLR_FLAGS = 1'b1;
      tick();
      CLR_FLAGS = 1'b0;
      checkOutput("t3_to_clr", timeout_err, 0);

      // 4: masked instance ignores ch 5, reads ch 0
      EOC_IN = 1'b1;
      CHANNEL_IN = 5'd5;
      tick();
      EOC_IN = 1'b0;
      checkOutput("t4_m_noden", den_m, 0);
      checkOutput("t4_m_idle", busy_m, 0);
      tick();
      DRDY = 1'b1;
      DO_IN = 16'h0000;
      tick();
      DRDY = 1'b0;
      checkOutput("t4_m_novalid", sample_valid_m, 0);
      checkOutput("t4_ch5", sample_ch, 5'd5);
      SAMPLE_READY = 1'b1;
      tick();
      SAMPLE_READY = 1'b0;
      EOC_IN = 1'b1;
      CHANNEL_IN = 5'd0;
      tick();
      EOC_IN = 1'b0;
      checkOutput("t4_m_den", den_m, 1);
      checkOutput("t4_m_daddr", daddr_m, 7'h00);
      tick();
      DRDY = 1'b1;
      DO_IN = 16'h7770;
      tick();
      DRDY = 1'b0;
      checkOutput("t4_m_sample", sample_m, 12'h777);
      checkOutput("t4_m_den_cnt", den_m_cnt, 1);
      SAMPLE_READY = 1'b1;
      tick();
      SAMPLE_READY = 1'b0;

      // 5: EOC while busy is lost, then back-to-back with READY held
      den_snap = den_cnt;
      EOC_IN = 1'b1;
      CHANNEL_IN = 5'd6;
      tick();
      EOC_IN = 1'b0;
      tick();
      EOC_IN = 1'b1;
      CHANNEL_IN = 5'd7;
      tick();
      EOC_IN = 1'b0;
      tick();
      checkOutput("t5_ovf", overflow, 1);
      DRDY = 1'b1;
      DO_IN = 16'h9990;
      tick();
      DRDY = 1'b0;
      repeat (3) tick();
      checkOutput("t5_one_den", den_cnt - den_snap, 1);
      checkOutput("t5_sample", sample, 12'h999);
      checkOutput("t5_ch", sample_ch, 5'd6);
      CLR_FLAGS = 1'b1;
      SAMPLE_READY = 1'b1;
      tick();
      CLR_FLAGS = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(5'(8 + i), {12'h100 + 12'(i), 4'h5}, 0);
         checkOutput("t5_b2b_sample", sample, 12'h100 + 12'(i));
         checkOutput("t5_b2b_ch", sample_ch, 8 + i);
         checkOutput("t5_b2b_valid", sample_valid, 1);
      end
      checkOutput("t5_b2b_ovf", overflow, 0);
      tick();
      SAMPLE_READY = 1'b0;

      // 6: reset in the middle of WAIT, late DRDY ignored
      EOC_IN = 1'b1;
      CHANNEL_IN = 5'd11;
      tick();
      EOC_IN = 1'b0;
      repeat (2) tick();
      RESETN = 1'b0;
      #1;
      checkOutput("t6_busy", busy, 0);
      checkOutput("t6_daddr", daddr, 0);
      checkOutput("t6_sample", sample, 0);
      checkOutput("t6_ch", sample_ch, 0);
      RESETN = 1'b1;
      DRDY = 1'b1;
      DO_IN = 16'hEEE0;
      tick();
      DRDY = 1'b0;
      tick();
      checkOutput("t6_novalid", sample_valid, 0);
      checkOutput("t6_idle", busy, 0);
      applyStimulus(5'd12, 16'h5550, 1);
      checkOutput("t6_after", sample, 12'h555);
      checkOutput("t6_after_ch", sample_ch, 5'd12);
      checkOutput("t6_after_daddr", daddr, 7'h0C);
      checkOutput("t6_after_valid", sample_valid, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
